// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the parameterised mux/arbiter.
package mux_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width that never collapses to zero bits, even for n <= 2.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/param_mux_arb_if.sv
// Channel-side and output-side signals of param_mux_arb grouped as one bus.
interface param_mux_arb_if #(
    parameter int N = 10,
    parameter int W = 8
);
    import mux_arb_pkg::*;
    localparam int SW = clog2_min1(N);

    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  sel;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_ready;
    logic           sel_err;

    modport master (
        output in_valid, in_data, mode, sel, out_ready,
        input  in_ready, out_valid, out_data, out_ch, sel_err
    );

    modport slave (
        input  in_valid, in_data, mode, sel, out_ready,
        output in_ready, out_valid, out_data, out_ch, sel_err
    );

endinterface

// File: rtl/param_mux_arb_rr_pick.sv
// Rotating-priority search: first requester at or above ptr, wrapping N-1 -> 0.
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter  int N  = 10,
    localparam int SW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          gnt_vld,
    output logic [SW-1:0] gnt_idx
);

    int            j;
    logic [SW-1:0] jj;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        j       = 0;
        jj      = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            jj = SW'(j);
            if (!gnt_vld && req[jj]) begin
                gnt_vld = 1'b1;
                gnt_idx = jj;
            end
        end
    end

endmodule

// File: rtl/param_mux_arb.sv
// N-channel mux into a one-deep output register, fixed-select or round-robin.
// Optional feature: define PARAM_MUX_ARB_CNT_EN to add the xfer_cnt handshake counter.
module param_mux_arb
    import mux_arb_pkg::*;
#(
    parameter  int N  = 10,
    parameter  int W  = 8,
    localparam int SW = clog2_min1(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    param_mux_arb_if.slave bus
`ifdef PARAM_MUX_ARB_CNT_EN
    ,
    output logic [15:0]    xfer_cnt
`endif
);

    localparam logic [SW:0] N_LIM = (SW + 1)'(N);

    logic [W-1:0]  ch_data [N];
    logic [SW-1:0] ptr;
    logic          rr_vld;
    logic [SW-1:0] rr_idx;
    logic          sel_ok;
    logic          load_en;
    logic          gnt_vld;
    logic [SW-1:0] gnt_idx;
    logic          grant;
    logic [SW-1:0] ptr_next;

    for (genvar i = 0; i < N; i++) begin : g_split
        assign ch_data[i] = bus.in_data[i*W +: W];
    end

    rr_pick #(.N(N)) u_pick (
        .req     (bus.in_valid),
        .ptr     (ptr),
        .gnt_vld (rr_vld),
        .gnt_idx (rr_idx)
    );

    assign sel_ok  = ({1'b0, bus.sel} < N_LIM);
    assign load_en = !bus.out_valid || bus.out_ready;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (bus.mode == MODE_FIXED) begin
            gnt_vld = sel_ok && bus.in_valid[bus.sel];
            gnt_idx = bus.sel;
        end else begin
            gnt_vld = rr_vld;
            gnt_idx = rr_idx;
        end
    end

    // Gating with rst_n keeps in_ready quiet while the block is held in reset.
    assign grant        = gnt_vld && load_en && rst_n;
    assign bus.in_ready = grant ? (N'(1) << gnt_idx) : '0;
    assign ptr_next     = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            bus.sel_err   <= 1'b0;
            ptr           <= '0;
        end else begin
            bus.sel_err <= (bus.mode == MODE_FIXED) && !sel_ok;
            if (grant) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= ch_data[gnt_idx];
                bus.out_ch    <= gnt_idx;
                if (bus.mode == MODE_RR) ptr <= ptr_next;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

`ifdef PARAM_MUX_ARB_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/param_mux_arb.md
PARAM_MUX_ARB -- requirements
Module: param_mux_arb

Interface
REQ-001 SHALL have parameter N, default 10, number of input channels (2..64).
REQ-002 SHALL have parameter W, default 8, data width per channel (1..64).
REQ-003 SHALL derive localparam SW = max(1, clog2(N)), the channel-index width.
REQ-004 clk  input  1  rising-edge clock; the single clock of the block.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  N  per-channel data-valid.
REQ-007 in_data  input  N*W  channel i occupies bits [i*W +: W].
REQ-008 in_ready  output  N  per-channel accept, one-hot or zero.
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 sel  input  SW  channel index used when mode=0.
REQ-011 out_valid  output  1  output register holds data.
REQ-012 out_data  output  W  registered selected data.
REQ-013 out_ch  output  SW  index of the channel that produced out_data.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 sel_err  output  1  registered flag: mode=0 and sel>=N.

Function
REQ-016 Output register SHALL load when (!out_valid | out_ready), called load_en.
REQ-017 mode=0: grant channel sel iff sel<N, in_valid[sel] and load_en; otherwise no grant.
REQ-018 mode=1: grant the first valid channel at or after ptr, scanning upward and wrapping N-1 -> 0, iff load_en.
REQ-019 in_ready SHALL equal the grant vector combinationally; a transfer occurs when in_valid[i] & in_ready[i].
REQ-020 On transfer, out_data/out_ch SHALL take the granted channel's data and index at the next edge, giving 1-cycle latency, and out_valid SHALL be set.
REQ-021 out_valid & out_ready with no new grant SHALL clear out_valid at the next edge.
REQ-022 Drain and load in the same cycle SHALL give back-to-back output, one transfer per cycle.
REQ-023 out_data/out_ch SHALL hold stable while out_valid & !out_ready.
REQ-024 ptr (SW bits) SHALL update to (granted index + 1) mod N on every round-robin transfer; it SHALL be unchanged otherwise, including on mode switches and fixed-mode transfers.
REQ-025 sel_err SHALL be registered each cycle as (mode==0 & sel>=N) and SHALL never cause a grant.
REQ-026 No valid input in round-robin mode SHALL give no grant and leave ptr unchanged.

Reset
REQ-027 rst_n low SHALL immediately set out_valid=0, out_data=0, out_ch=0, ptr=0 and sel_err=0, and counter=0 if present.
REQ-028 in_ready SHALL be all-zero while rst_n is low.
REQ-029 Reset mid-transfer SHALL discard held data, with no replay after release.

Configuration
REQ-030 Macro PARAM_MUX_ARB_CNT_EN, when defined, SHALL add output xfer_cnt (16 bits), incrementing on each output handshake (out_valid & out_ready) and wrapping 0xFFFF -> 0.
REQ-031 Without PARAM_MUX_ARB_CNT_EN, the port and the counter logic SHALL be absent, with function otherwise identical.

Structure
REQ-032 Package mux_arb_pkg SHALL hold the mode encoding constants (MODE_FIXED=0, MODE_RR=1) and a clog2-with-min-1 function.
REQ-033 Sub-module rr_pick (parameter N; inputs req[N] and ptr; outputs gnt_vld and gnt_idx) SHALL implement the rotating priority search; everything else stays in param_mux_arb.

Verification
REQ-034 N=10, W=8, mode=0, in_valid=all ones, in_data[i]=0x10+i, out_ready=1, sel stepped 0..9 -> out_data 0x10..0x19 each one cycle after its sel, with out_ch matching.
REQ-035 mode=0, sel=12 -> in_ready=0, out_valid stays 0, sel_err=1 from the next cycle; sel=3 -> sel_err=0 next cycle.
REQ-036 mode=1, in_valid=0b10_0000_0101, out_ready=1 -> out_ch sequence 0,2,9,0,2,9 back-to-back and ptr wraps 9 -> 0.
REQ-037 mode=1, out_ready=0 for 5 cycles after the first load -> out_data/out_ch frozen, in_ready=0; on release, the next channel follows with no bubble.
REQ-038 Assert rst_n=0 asynchronously mid-stream -> out_valid=0, out_data=0, out_ch=0 without a clock edge; after release, the first round-robin grant is the lowest valid index.
REQ-039 With PARAM_MUX_ARB_CNT_EN, 65537 handshakes -> xfer_cnt=1; with stalls, the count equals the number of out_valid&out_ready cycles.
